// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache lookup stage: sweep FSM
// states, default geometry and the position of the way-valid status bit.
package icache_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_SET_BITS     = 4;
    localparam int DEF_NUM_WAYS     = 4;
    localparam int DEF_TAG_WIDTH    = 8;
    localparam int DEF_STATUS_WIDTH = 2;

    // Status bit 0 of every way marks the way as holding a live line.
    localparam int WAY_VALID_BIT = 0;

endpackage

// File: rtl/icache_way_array.sv
// One per-set array of NUM_WAYS entries (used for tags and for status).
// Masked per-way synchronous write, one-cycle registered read of the whole
// set that holds while halted. Optional write-to-read forwarding is
// selected with the ICACHE_LOOKUP_BYPASS_EN macro.
module icache_way_array #(
    parameter int ENTRY_W  = 8,
    parameter int NUM_WAYS = 4,
    parameter int SET_BITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_halt,
    input  logic                         i_rd_en,
    input  logic [SET_BITS-1:0]          i_rd_set,
    input  logic                         i_wr_en,
    input  logic [SET_BITS-1:0]          i_wr_set,
    input  logic [NUM_WAYS*ENTRY_W-1:0]  i_wr_data,
    input  logic [NUM_WAYS-1:0]          i_wr_mask,
    output logic [NUM_WAYS*ENTRY_W-1:0]  o_rd_data,
    output logic                         o_rd_valid
);

    localparam int NUM_SETS = 2**SET_BITS;

    logic [ENTRY_W-1:0]          mem [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS*ENTRY_W-1:0] rd_word_p0;
    logic [NUM_WAYS*ENTRY_W-1:0] rd_data_p1;
    logic                        vld_p1;

    // Update only the ways selected by the mask; others keep their contents.
    always_ff @(posedge clk) begin
        if (i_wr_en && !i_halt) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (i_wr_mask[w]) begin
                    mem[i_wr_set][w] <= i_wr_data[w*ENTRY_W +: ENTRY_W];
                end
            end
        end
    end

    // Gather every way of the addressed set, optionally forwarding write data.
    always_comb begin
        rd_word_p0 = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            rd_word_p0[w*ENTRY_W +: ENTRY_W] = mem[i_rd_set][w];
`ifdef ICACHE_LOOKUP_BYPASS_EN
            if (i_wr_en && i_wr_mask[w] && (i_wr_set == i_rd_set)) begin
                rd_word_p0[w*ENTRY_W +: ENTRY_W] = i_wr_data[w*ENTRY_W +: ENTRY_W];
            end
`endif
        end
    end

    // p0 -> p1: register the lookup; data holds when no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
        end else if (!i_halt) begin
            vld_p1 <= i_rd_en;
            if (i_rd_en) begin
                rd_data_p1 <= rd_word_p0;
            end
        end
    end

    assign o_rd_data  = rd_data_p1;
    assign o_rd_valid = vld_p1;

endmodule

// File: rtl/icache_lookup_stage.sv
// First stage of the instruction-cache pipeline: tag and status arrays,
// one-cycle lookup of all ways, metadata sideband, and a status
// invalidation sweep after reset or flush. Defining ICACHE_LOOKUP_BYPASS_EN
// forwards same-cycle same-set write data into the lookup result.
module icache_lookup_stage
    import icache_pkg::*;
#(
    parameter int METADATA_WIDTH = 16,
    parameter int SET_BITS       = DEF_SET_BITS,
    parameter int NUM_WAYS       = DEF_NUM_WAYS,
    parameter int TAG_WIDTH      = DEF_TAG_WIDTH,
    parameter int STATUS_WIDTH   = DEF_STATUS_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_halt,
    input  logic                              i_flush,
    input  logic [METADATA_WIDTH-1:0]         i_metadata,
    input  logic                              i_metadata_valid,
    input  logic [SET_BITS-1:0]               i_r_set_addr,
    input  logic                              i_r_valid,
    input  logic [SET_BITS-1:0]               i_w_ta_set_addr,
    input  logic [NUM_WAYS*TAG_WIDTH-1:0]     i_w_ta_data,
    input  logic [NUM_WAYS-1:0]               i_w_ta_mask,
    input  logic                              i_w_ta_valid,
    input  logic [SET_BITS-1:0]               i_w_sa_set_addr,
    input  logic [NUM_WAYS*STATUS_WIDTH-1:0]  i_w_sa_data,
    input  logic [NUM_WAYS-1:0]               i_w_sa_mask,
    input  logic                              i_w_sa_valid,
    output logic [NUM_WAYS*TAG_WIDTH-1:0]     o_ta_data,
    output logic                              o_ta_data_valid,
    output logic [NUM_WAYS*STATUS_WIDTH-1:0]  o_sa_data,
    output logic                              o_sa_data_valid,
    output logic [METADATA_WIDTH-1:0]         o_metadata,
    output logic                              o_metadata_valid,
    output logic                              o_ready,
    output logic                              o_init_busy
);

    localparam int NUM_SETS = 2**SET_BITS;

    state_t                           state;
    logic [SET_BITS-1:0]              sweep_cnt;
    logic                             sweep_we;
    logic                             rd_en_p0;
    logic                             ta_we_p0;
    logic                             sa_we_p0;
    logic [SET_BITS-1:0]              sa_set_p0;
    logic [NUM_WAYS*STATUS_WIDTH-1:0] sa_data_p0;
    logic [NUM_WAYS-1:0]              sa_mask_p0;
    logic [METADATA_WIDTH-1:0]        md_p1;
    logic                             vld_md_p1;

    assign o_ready     = ~i_halt & (state == RUN);
    assign o_init_busy = (state == INIT);

    assign rd_en_p0 = o_ready & i_r_valid;
    assign ta_we_p0 = o_ready & i_w_ta_valid;
    assign sweep_we = (state == INIT) & ~i_halt;

    // The sweep borrows the status write port to clear one whole set per cycle.
    assign sa_we_p0   = sweep_we | (o_ready & i_w_sa_valid);
    assign sa_set_p0  = sweep_we ? sweep_cnt : i_w_sa_set_addr;
    assign sa_data_p0 = sweep_we ? '0 : i_w_sa_data;
    assign sa_mask_p0 = sweep_we ? {NUM_WAYS{1'b1}} : i_w_sa_mask;

    // Sweep FSM: INIT clears status set by set, RUN serves lookups; flush re-enters INIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            sweep_cnt <= '0;
        end else if (!i_halt) begin
            case (state)
                INIT: begin
                    if (i_flush) begin
                        sweep_cnt <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + SET_BITS'(1);
                        if (sweep_cnt == SET_BITS'(NUM_SETS - 1)) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (i_flush) begin
                        state     <= INIT;
                        sweep_cnt <= '0;
                    end
                end
                default: begin
                    state     <= INIT;
                    sweep_cnt <= '0;
                end
            endcase
        end
    end

    // p0 -> p1: sideband data follows every unhalted cycle, its valid only when ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_p1     <= '0;
            vld_md_p1 <= 1'b0;
        end else if (!i_halt) begin
            md_p1     <= i_metadata;
            vld_md_p1 <= i_metadata_valid & o_ready;
        end
    end

    assign o_metadata       = md_p1;
    assign o_metadata_valid = vld_md_p1;

    icache_way_array #(
        .ENTRY_W  (TAG_WIDTH),
        .NUM_WAYS (NUM_WAYS),
        .SET_BITS (SET_BITS)
    ) u_tag_array (
        .clk        (clk),
        .rst        (rst),
        .i_halt     (i_halt),
        .i_rd_en    (rd_en_p0),
        .i_rd_set   (i_r_set_addr),
        .i_wr_en    (ta_we_p0),
        .i_wr_set   (i_w_ta_set_addr),
        .i_wr_data  (i_w_ta_data),
        .i_wr_mask  (i_w_ta_mask),
        .o_rd_data  (o_ta_data),
        .o_rd_valid (o_ta_data_valid)
    );

    icache_way_array #(
        .ENTRY_W  (STATUS_WIDTH),
        .NUM_WAYS (NUM_WAYS),
        .SET_BITS (SET_BITS)
    ) u_status_array (
        .clk        (clk),
        .rst        (rst),
        .i_halt     (i_halt),
        .i_rd_en    (rd_en_p0),
        .i_rd_set   (i_r_set_addr),
        .i_wr_en    (sa_we_p0),
        .i_wr_set   (sa_set_p0),
        .i_wr_data  (sa_data_p0),
        .i_wr_mask  (sa_mask_p0),
        .o_rd_data  (o_sa_data),
        .o_rd_valid (o_sa_data_valid)
    );

endmodule

// File: tb/tb_icache_lookup_stage.sv
// Scoreboard bench for icache_lookup_stage (default geometry: 16 sets,
// 4 ways, 8-bit tags, 2-bit status, 16-bit metadata). Expectations follow
// ICACHE_LOOKUP_BYPASS_EN when it is defined for the build.
module tb_icache_lookup_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_halt;
    logic        i_flush;
    logic [15:0] i_metadata;
    logic        i_metadata_valid;
    logic [3:0]  i_r_set_addr;
    logic        i_r_valid;
    logic [3:0]  i_w_ta_set_addr;
    logic [31:0] i_w_ta_data;
    logic [3:0]  i_w_ta_mask;
    logic        i_w_ta_valid;
    logic [3:0]  i_w_sa_set_addr;
    logic [7:0]  i_w_sa_data;
    logic [3:0]  i_w_sa_mask;
    logic        i_w_sa_valid;
    logic [31:0] o_ta_data;
    logic        o_ta_data_valid;
    logic [7:0]  o_sa_data;
    logic        o_sa_data_valid;
    logic [15:0] o_metadata;
    logic        o_metadata_valid;
    logic        o_ready;
    logic        o_init_busy;

    icache_lookup_stage dut (
        .clk              (clk),
        .rst              (rst),
        .i_halt           (i_halt),
        .i_flush          (i_flush),
        .i_metadata       (i_metadata),
        .i_metadata_valid (i_metadata_valid),
        .i_r_set_addr     (i_r_set_addr),
        .i_r_valid        (i_r_valid),
        .i_w_ta_set_addr  (i_w_ta_set_addr),
        .i_w_ta_data      (i_w_ta_data),
        .i_w_ta_mask      (i_w_ta_mask),
        .i_w_ta_valid     (i_w_ta_valid),
        .i_w_sa_set_addr  (i_w_sa_set_addr),
        .i_w_sa_data      (i_w_sa_data),
        .i_w_sa_mask      (i_w_sa_mask),
        .i_w_sa_valid     (i_w_sa_valid),
        .o_ta_data        (o_ta_data),
        .o_ta_data_valid  (o_ta_data_valid),
        .o_sa_data        (o_sa_data),
        .o_sa_data_valid  (o_sa_data_valid),
        .o_metadata       (o_metadata),
        .o_metadata_valid (o_metadata_valid),
        .o_ready          (o_ready),
        .o_init_busy      (o_init_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ta;
        logic [7:0]  sa;
        logic [15:0] md;
        bit          chk_ta;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    exp_t mon_e;
    bit   mon_have;
    logic halt_q = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Remember whether the edge that produced the current outputs was halted.
    always @(posedge clk) halt_q <= i_halt;

    // Monitor: every presented lookup is compared with the next expectation;
    // during a halt the outputs must still show the last one.
    always @(negedge clk) begin
        if (o_ta_data_valid || o_sa_data_valid || o_metadata_valid) begin
            mon_have = 1'b1;
            if (halt_q) begin
                mon_e = last_exp;
            end else if (sb_q.size() == 0) begin
                mon_have = 1'b0;
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid t=%0t ta_v=%0b sa_v=%0b md_v=%0b required none",
                         $time, o_ta_data_valid, o_sa_data_valid, o_metadata_valid);
            end else begin
                mon_e = sb_q.pop_front();
                last_exp = mon_e;
            end
            if (mon_have) begin
                n_checks++;
                if (!(o_ta_data_valid && o_sa_data_valid && o_metadata_valid) ||
                    (o_sa_data !== mon_e.sa) || (o_metadata !== mon_e.md) ||
                    (mon_e.chk_ta && (o_ta_data !== mon_e.ta))) begin
                    n_errors++;
                    $display("FAIL lookup t=%0t halt=%0b got ta=%h sa=%h md=%h vld=%0b%0b%0b required ta=%h(chk %0b) sa=%h md=%h vld=111",
                             $time, halt_q, o_ta_data, o_sa_data, o_metadata,
                             o_ta_data_valid, o_sa_data_valid, o_metadata_valid,
                             mon_e.ta, mon_e.chk_ta, mon_e.sa, mon_e.md);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s got %h required %h", nm, act, req);
        end
    endtask

    task automatic clear_req();
        i_r_valid        = 1'b0;
        i_metadata_valid = 1'b0;
        i_w_ta_valid     = 1'b0;
        i_w_sa_valid     = 1'b0;
        i_flush          = 1'b0;
    endtask

    task automatic cycle();
        tick();
        clear_req();
    endtask

    task automatic read_req(input logic [3:0] set, input logic [31:0] ta, input bit chk_ta,
                            input logic [7:0] sa, input logic [15:0] md);
        exp_t e;
        i_r_valid        = 1'b1;
        i_r_set_addr     = set;
        i_metadata       = md;
        i_metadata_valid = 1'b1;
        e.ta = ta; e.sa = sa; e.md = md; e.chk_ta = chk_ta;
        sb_q.push_back(e);
    endtask

    task automatic tag_wr(input logic [3:0] set, input logic [31:0] data, input logic [3:0] mask);
        i_w_ta_valid    = 1'b1;
        i_w_ta_set_addr = set;
        i_w_ta_data     = data;
        i_w_ta_mask     = mask;
    endtask

    task automatic sa_wr(input logic [3:0] set, input logic [7:0] data, input logic [3:0] mask);
        i_w_sa_valid    = 1'b1;
        i_w_sa_set_addr = set;
        i_w_sa_data     = data;
        i_w_sa_mask     = mask;
    endtask

    // Expects INIT for 16 cycles from now, then RUN; optionally pokes a read
    // and a metadata valid in the first sweep cycle, which must not be accepted.
    task automatic sweep_wait(input string nm, input bit poke);
        for (int i = 0; i < 16; i++) begin
            chk({nm, "_busy"}, {30'd0, o_init_busy, o_ready}, 32'h2);
            if (poke && i == 0) begin
                i_r_valid        = 1'b1;
                i_r_set_addr     = 4'd2;
                i_metadata_valid = 1'b1;
            end
            cycle();
        end
        chk({nm, "_ready"}, {30'd0, o_init_busy, o_ready}, 32'h1);
    endtask

    logic [7:0] exp_coll_full;
    logic [7:0] exp_coll_part;

    initial begin
`ifdef ICACHE_LOOKUP_BYPASS_EN
        exp_coll_full = 8'hFF;
        exp_coll_part = 8'hF0;
`else
        exp_coll_full = 8'h66;
        exp_coll_part = 8'hFF;
`endif
        rst = 1'b1; i_halt = 1'b0; i_metadata = '0;
        i_r_set_addr = '0; i_w_ta_set_addr = '0; i_w_ta_data = '0; i_w_ta_mask = '0;
        i_w_sa_set_addr = '0; i_w_sa_data = '0; i_w_sa_mask = '0;
        clear_req();
        tick(); tick();

        // Reset state
        chk("rst_busy_ready", {30'd0, o_init_busy, o_ready}, 32'h2);
        chk("rst_valids", {29'd0, o_ta_data_valid, o_sa_data_valid, o_metadata_valid}, 32'h0);
        chk("rst_ta", o_ta_data, 32'h0);
        chk("rst_sa", {24'd0, o_sa_data}, 32'h0);
        chk("rst_md", {16'd0, o_metadata}, 32'h0);

        rst = 1'b0;
        sweep_wait("post_rst", 1'b0);

        // Every set reads status 0 after the sweep, back to back
        for (int s = 0; s < 16; s++) begin
            read_req(4'(s), 32'h0, 1'b0, 8'h00, 16'h1000 + 16'(s));
            cycle();
        end

        // Masked tag write
        tag_wr(4'd3, 32'h11223344, 4'b1111); cycle();
        tag_wr(4'd3, 32'hAABBCCDD, 4'b0101); cycle();
        read_req(4'd3, 32'h11BB33DD, 1'b1, 8'h00, 16'h0003); cycle();

        // Independent tag and status writes to different sets in one cycle
        tag_wr(4'd7, 32'hDEADBEEF, 4'b1111);
        sa_wr(4'd12, 8'hAA, 4'b1010); cycle();
        read_req(4'd12, 32'h0, 1'b0, 8'h88, 16'h000C); cycle();
        read_req(4'd7, 32'hDEADBEEF, 1'b1, 8'h00, 16'h0007); cycle();

        // Same-cycle same-set write and read of status
        sa_wr(4'd5, 8'h66, 4'b1111); cycle();
        sa_wr(4'd5, 8'hFF, 4'b1111);
        read_req(4'd5, 32'h0, 1'b0, exp_coll_full, 16'h0055); cycle();
        sa_wr(4'd5, 8'h00, 4'b0011);
        read_req(4'd5, 32'h0, 1'b0, exp_coll_part, 16'h0056); cycle();
        read_req(4'd5, 32'h0, 1'b0, 8'hF0, 16'h0057); cycle();

        // Halt for 3 cycles after a read; write, read and flush must be ignored
        tag_wr(4'd9, 32'h01020304, 4'b1111); cycle();
        read_req(4'd9, 32'h01020304, 1'b1, 8'h00, 16'hBEEF); cycle();
        i_halt = 1'b1;
        tag_wr(4'd9, 32'h55555555, 4'b1111);
        i_r_valid = 1'b1; i_r_set_addr = 4'd3;
        i_metadata = 16'h1234;
        i_flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("halt_ready", {30'd0, o_init_busy, o_ready}, 32'h0);
            tick();
        end
        i_halt = 1'b0;
        clear_req();
        i_metadata = '0;
        tick();
        chk("after_halt_valid", {29'd0, o_ta_data_valid, o_sa_data_valid, o_metadata_valid}, 32'h0);
        chk("after_halt_ready", {30'd0, o_init_busy, o_ready}, 32'h1);
        read_req(4'd9, 32'h01020304, 1'b1, 8'h00, 16'h0009); cycle();

        // Flush: read in the flush cycle completes, then status cleared, tags kept
        sa_wr(4'd2, 8'h55, 4'b1111);
        tag_wr(4'd2, 32'hCAFEF00D, 4'b1111); cycle();
        read_req(4'd2, 32'hCAFEF00D, 1'b1, 8'h55, 16'h0002); cycle();
        read_req(4'd2, 32'hCAFEF00D, 1'b1, 8'h55, 16'h0F02);
        i_flush = 1'b1; cycle();
        sweep_wait("flush", 1'b1);
        read_req(4'd2, 32'hCAFEF00D, 1'b1, 8'h00, 16'h2002); cycle();
        read_req(4'd5, 32'h0, 1'b0, 8'h00, 16'h2005); cycle();
        read_req(4'd12, 32'h0, 1'b0, 8'h00, 16'h200C); cycle();
        read_req(4'd3, 32'h11BB33DD, 1'b1, 8'h00, 16'h2003); cycle();

        // rst at sweep counter 7 restarts the sweep
        i_flush = 1'b1; cycle();
        repeat (7) tick();
        chk("mid_sweep_busy", {30'd0, o_init_busy, o_ready}, 32'h2);
        rst = 1'b1; tick();
        rst = 1'b0;
        sweep_wait("mid_sweep_rst", 1'b0);

        // rst in the same cycle as a read: no lookup is presented
        read_req(4'd3, 32'h0, 1'b0, 8'h00, 16'h0);
        void'(sb_q.pop_back());
        rst = 1'b1; cycle();
        rst = 1'b0;
        chk("rst_read_valid", {29'd0, o_ta_data_valid, o_sa_data_valid, o_metadata_valid}, 32'h0);
        chk("rst_read_ta", o_ta_data, 32'h0);
        sweep_wait("rst_read", 1'b0);
        read_req(4'd3, 32'h11BB33DD, 1'b1, 8'h00, 16'h3003); cycle();

        tick(); tick();
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/icache_lookup_stage.md
# icache_lookup_stage

Parametrised first stage of the instruction-cache pipeline. It holds the per-set tag array and status array as internal flop arrays and performs a registered one-cycle lookup of every way of the addressed set. It carries a metadata sideband alongside each lookup. It also adds what the fixed 4-way stage lacked: a post-reset/flush invalidation sweep, per-way masked writes at any geometry, and optional write-to-read forwarding.

## Interface
- METADATA_WIDTH, 16, sideband width carried with each lookup
- SET_BITS, 4, set-index width; number of sets NUM_SETS = 2**SET_BITS
- NUM_WAYS, 4, associativity; must be ≥ 1
- TAG_WIDTH, 8, tag bits stored per way
- STATUS_WIDTH, 2, status bits per way; bit 0 is the way-valid bit
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- i_halt  in  1  pipeline stall; freezes all state
- i_flush  in  1  one-cycle pulse; invalidates every status entry
- i_metadata / i_metadata_valid  in  METADATA_WIDTH / 1  sideband and its valid
- i_r_set_addr / i_r_valid  in  SET_BITS / 1  lookup request
- i_w_ta_set_addr, i_w_ta_data, i_w_ta_mask, i_w_ta_valid  in  SET_BITS, NUM_WAYS*TAG_WIDTH, NUM_WAYS, 1  tag write; way w occupies data bits [w*TAG_WIDTH +: TAG_WIDTH]
- i_w_sa_set_addr, i_w_sa_data, i_w_sa_mask, i_w_sa_valid  in  SET_BITS, NUM_WAYS*STATUS_WIDTH, NUM_WAYS, 1  status write; same packing
- o_ta_data / o_ta_data_valid  out  NUM_WAYS*TAG_WIDTH / 1  all tags of the looked-up set
- o_sa_data / o_sa_data_valid  out  NUM_WAYS*STATUS_WIDTH / 1  all status entries of the set
- o_metadata / o_metadata_valid  out  METADATA_WIDTH / 1  registered sideband
- o_ready  out  1  stage accepts reads and writes this cycle
- o_init_busy  out  1  invalidation sweep in progress

## Operation
- FSM states: INIT and RUN. rst forces INIT with sweep counter = 0.
- INIT (not halted): writes status = 0 for all ways of set `counter`, then increments the counter. On counter == NUM_SETS-1, goes to RUN next cycle. The tag array is not cleared.
- RUN: i_flush (not halted) returns to INIT with counter = 0. i_flush during INIT restarts the counter at 0.
- o_ready = ~i_halt & (state == RUN). o_init_busy = (state == INIT).
- Reads are accepted only when o_ready & i_r_valid. Writes are performed only when o_ready & i_w_*_valid.
- Writes: only ways with a mask bit set are updated; all others are untouched. A mask of all zero is a no-op. Tag and status writes are independent and may target different sets in the same cycle.
- Read/write collision (same set, same cycle): the read returns pre-write contents (read-before-write), unless forwarding is enabled (see Configuration).
- Output valids: o_ta_data_valid and o_sa_data_valid are registered from (read accepted). o_metadata_valid is registered from (i_metadata_valid & o_ready).
- o_metadata data captures i_metadata every non-halted cycle.
- Output data registers hold their last value when no read is accepted; only the valids drop.
- i_halt: array contents, output registers, FSM state and counter all hold. i_flush is ignored while halted.

## Timing
- Lookup latency is 1 cycle: a read accepted at edge N is presented on the outputs after edge N+1. Throughput is 1 lookup per cycle.
- A write at edge N is visible to a read accepted at edge N+1 or later.
- Reset values: all output valids 0, o_ta_data 0, o_sa_data 0, o_metadata 0, o_ready 0, o_init_busy 1. The status array is undefined until the sweep completes.
- After rst deasserts, o_ready first goes high NUM_SETS cycles later, assuming no halt. Each halted cycle adds one cycle.
- rst mid-sweep or mid-lookup: valids go to 0 the next cycle and the sweep restarts at 0.
- Flush to RUN takes NUM_SETS unhalted cycles. A read accepted in the flush cycle itself is still completed.

## Configuration
- ICACHE_LOOKUP_BYPASS_EN defined: on a same-cycle same-set collision, each way whose write-mask bit is set returns the new write data in the lookup result. This applies to tag and status separately; unmasked ways return stored data.
- ICACHE_LOOKUP_BYPASS_EN undefined: no forwarding; collisions return the old contents.

## Structure
- Shared package icache_pkg holds:
  - FSM state typedef (INIT, RUN)
  - default widths: SET_BITS, NUM_WAYS, TAG_WIDTH, STATUS_WIDTH
  - helper constant for the way-valid bit index
- One sub-module, icache_way_array, parametrised by entry width and way count. It provides a masked per-way synchronous write, a registered read with halt hold, and the optional bypass mux. It is instantiated once for tags and once for status.
- The sweep FSM and the metadata register live in the top module.

## Test plan
- Reset then idle -> o_init_busy stays high for 16 cycles, o_ready rises on cycle 16, and all status reads return 0.
- Tag write set 3, data 0xAABBCCDD, mask 4'b0101, then read set 3 -> o_ta_data = 0x??BB??DD, with ways 1 and 3 unchanged, valid one cycle after the read.
- Same-cycle write and read of set 5, status data 0xFF, mask 4'b1111 -> old status returned without the macro; 0xFF returned with ICACHE_LOOKUP_BYPASS_EN.
- Read issued, then i_halt asserted for 3 cycles -> outputs and valids frozen, o_ready 0, and a write presented during the halt is not performed.
- i_flush after valid status writes -> o_ready low for 16 cycles, then all sets read status 0 while tags are preserved.
- rst pulsed at sweep counter 7 -> the sweep restarts and o_ready rises 16 cycles after rst deasserts.
